serial_add_ctrl: RTL and testbench



---
 rtl/serial_add_ctrl.sv | 126 ++++++++++++
 tb/tb_serial_add_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one shared Full_adder cell, one bit per clock, LSB first.
// Optional subtract mode is enabled by defining SERIAL_SUB_EN (adds the sub input).

module Full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);
   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

// state | meaning
// IDLE  | waiting for start; operands captured on the accepted start
// RUN   | one operand bit per cycle through the adder cell, busy=1
// DONE  | single-cycle done pulse, result registers updated on entry
module serial_add_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             cin_in,
`ifdef SERIAL_SUB_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum_out,
   output logic             cout_out
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]       state;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] s_sr;
   logic [WIDTH-1:0] s_next;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             fa_sum;
   logic             fa_cout;
   logic [WIDTH-1:0] b_load;
   logic             c_load;

   Full_adder u_fa (
      .a    (a_sr[0]),
      .b    (b_sr[0]),
      .cin  (carry),
      .sum  (fa_sum),
      .cout (fa_cout)
   );

   // Subtraction is a + ~b + 1; the final carry then reads as "no borrow".
   always_comb begin
      b_load = b_in;
      c_load = cin_in;
`ifdef SERIAL_SUB_EN
      if (sub) begin
         b_load = ~b_in;
         c_load = 1'b1;
      end
`endif
   end

   generate
      if (WIDTH == 1) begin : g_s_one
         assign s_next = fa_sum;
      end else begin : g_s_multi
         assign s_next = {fa_sum, s_sr[WIDTH-1:1]};
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         a_sr     <= '0;
         b_sr     <= '0;
         s_sr     <= '0;
         carry    <= 1'b0;
         cnt      <= '0;
         sum_out  <= '0;
         cout_out <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_sr  <= a_in;
                  b_sr  <= b_load;
                  carry <= c_load;
                  cnt   <= '0;
                  state <= RUN;
               end
            end
            RUN: begin
               a_sr  <= a_sr >> 1;
               b_sr  <= b_sr >> 1;
               s_sr  <= s_next;
               carry <= fa_cout;
               cnt   <= cnt + 1'b1;
               if (cnt == CNT_LAST) begin
                  sum_out  <= s_next;
                  cout_out <= fa_cout;
                  state    <= DONE;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign busy = (state == RUN);
   assign done = (state == DONE);

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: directed cases plus random operations
// against an arithmetic reference model; exercises sub mode when SERIAL_SUB_EN is defined.

module tb_serial_add_ctrl;
   localparam int W = 8;

   logic         clk;
   logic         rst;
   logic         start;
   logic [W-1:0] a_in;
   logic [W-1:0] b_in;
   logic         cin_in;
   logic         sub;
   logic         busy;
   logic         done;
   logic [W-1:0] sum_out;
   logic         cout_out;

   int n_checks = 0;
   int n_fail   = 0;

   logic [W-1:0] held_sum;
   logic         held_cout;

   serial_add_ctrl #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .a_in     (a_in),
      .b_in     (b_in),
      .cin_in   (cin_in),
`ifdef SERIAL_SUB_EN
      .sub      (sub),
`endif
      .busy     (busy),
      .done     (done),
      .sum_out  (sum_out),
      .cout_out (cout_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: addition is plain integer arithmetic; subtraction is modular
   // difference with carry meaning a >= b.
   task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input logic s, output logic [W-1:0] rs, output logic rc);
      int unsigned total;
      if (s) begin
         rs = W'(a - b);
         rc = (a >= b);
      end else begin
         total = int'(a) + int'(b) + int'(c);
         rs = W'(total);
         rc = total[W];
      end
   endtask

   // Starts one operation at the next IDLE cycle and checks it cycle by cycle.
   // poke_at >= 0 re-asserts start with a_in=F0 during that RUN cycle;
   // abort_at >= 0 asserts reset during that RUN cycle instead of finishing.
   task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic c, input logic s, input int poke_at, input int abort_at);
      logic [W-1:0] es;
      logic         ec;
      model(a, b, c, s, es, ec);
      @(negedge clk);
      check({tag, "_idle_busy"}, 32'(busy), 32'd0);
      check({tag, "_idle_done"}, 32'(done), 32'd0);
      start  = 1'b1;
      a_in   = a;
      b_in   = b;
      cin_in = c;
      sub    = s;
      @(posedge clk);
      #1;
      start  = 1'b0;
      a_in   = W'($urandom);
      b_in   = W'($urandom);
      cin_in = 1'($urandom);
      sub    = 1'($urandom);
      for (int i = 0; i < W; i++) begin
         @(negedge clk);
         start = 1'b0;
         check($sformatf("%s_run%0d_busy", tag, i), 32'(busy), 32'd1);
         check($sformatf("%s_run%0d_done", tag, i), 32'(done), 32'd0);
         check($sformatf("%s_run%0d_hold", tag, i), 32'({cout_out, sum_out}),
               32'({held_cout, held_sum}));
         if (i == abort_at) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            check({tag, "_abort_busy"}, 32'(busy), 32'd0);
            check({tag, "_abort_done"}, 32'(done), 32'd0);
            check({tag, "_abort_sum"}, 32'(sum_out), 32'd0);
            check({tag, "_abort_cout"}, 32'(cout_out), 32'd0);
            held_sum  = '0;
            held_cout = 1'b0;
            return;
         end
         if (i == poke_at) begin
            start = 1'b1;
            a_in  = 8'hF0;
         end
      end
      @(negedge clk);
      start = 1'b0;
      check({tag, "_done"}, 32'(done), 32'd1);
      check({tag, "_done_busy"}, 32'(busy), 32'd0);
      check({tag, "_sum"}, 32'(sum_out), 32'(es));
      check({tag, "_cout"}, 32'(cout_out), 32'(ec));
      held_sum  = es;
      held_cout = ec;
   endtask

   initial begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic         rc;
      logic         rsub;
      rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0; cin_in = 1'b0; sub = 1'b0;
      held_sum = '0; held_cout = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_sum", 32'(sum_out), 32'd0);
      check("rst_cout", 32'(cout_out), 32'd0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check($sformatf("idle%0d_done", i), 32'(done), 32'd0);
         check($sformatf("idle%0d_busy", i), 32'(busy), 32'd0);
      end

      run_op("basic", 8'h5A, 8'h33, 1'b0, 1'b0, -1, -1);
      run_op("carry1", 8'hFF, 8'h01, 1'b0, 1'b0, -1, -1);
      run_op("carry2", 8'hFF, 8'hFF, 1'b1, 1'b0, -1, -1);
      run_op("poke", 8'h01, 8'h01, 1'b0, 1'b0, 3, -1);
      @(negedge clk);
      check("poke_single_done", 32'(done), 32'd0);
      check("poke_ignored_busy", 32'(busy), 32'd0);
      run_op("abort", 8'h77, 8'h22, 1'b1, 1'b0, -1, 4);
      run_op("fresh", 8'h10, 8'h20, 1'b0, 1'b0, -1, -1);

`ifdef SERIAL_SUB_EN
      run_op("sub1", 8'h10, 8'h01, 1'b0, 1'b1, -1, -1);
      run_op("sub2", 8'h00, 8'h01, 1'b1, 1'b1, -1, -1);
      run_op("add_after_sub", 8'h10, 8'h01, 1'b0, 1'b0, -1, -1);
`endif

      for (int k = 0; k < 24; k++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         rc = 1'($urandom);
`ifdef SERIAL_SUB_EN
         rsub = 1'($urandom);
`else
         rsub = 1'b0;
`endif
         run_op($sformatf("rand%0d", k), ra, rb, rc, rsub, -1, -1);
      end

      @(negedge clk);
      check("final_idle_done", 32'(done), 32'd0);
      check("final_hold", 32'({cout_out, sum_out}), 32'({held_cout, held_sum}));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
